// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants and state encoding for the RV32M mul/div unit
package muldiv_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX,
      S_DONE
   } state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step
   import muldiv_pkg::*;
(
   input  logic [XLEN-1:0] i_rem,
   input  logic [XLEN-1:0] i_div,
   input  logic            i_bit,
   output logic [XLEN-1:0] o_rem,
   output logic            o_q
);

   logic [XLEN:0] w_shift;
   logic [XLEN:0] w_diff;

   assign w_shift = {i_rem, i_bit};
   assign w_diff  = w_shift - {1'b0, i_div};
   // i_rem < i_div on entry, so a non-negative difference always has a clear top bit
   assign o_q     = ~w_diff[XLEN];
   assign o_rem   = o_q ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit for the EX stage
module ex_muldiv_unit
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   state_t          r_state;
   logic [XLEN:0]   r_a;
   logic [XLEN:0]   r_b;
   logic [XLEN-1:0] r_quo;
   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_result;
   logic [4:0]      r_cnt;
   logic [2:0]      r_op;
   logic            r_neg_q;
   logic            r_neg_r;
   logic            r_done;

   logic            w_signed_div;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [XLEN-1:0] w_abs_a;
   logic [XLEN-1:0] w_abs_b;
   logic            w_div_zero;
   logic            w_ovf;
   logic            w_mul_a_sx;
   logic            w_mul_b_sx;
   logic [63:0]     w_prod;
   logic [XLEN-1:0] w_step_rem;
   logic            w_step_q;
   logic [XLEN-1:0] w_fix_quo;
   logic [XLEN-1:0] w_fix_rem;

   assign w_signed_div = ~funct3[0];
   assign w_a_neg      = w_signed_div & operand_a[XLEN-1];
   assign w_b_neg      = w_signed_div & operand_b[XLEN-1];
   assign w_abs_a      = w_a_neg ? -operand_a : operand_a;
   assign w_abs_b      = w_b_neg ? -operand_b : operand_b;
   assign w_div_zero   = (operand_b == '0);
   assign w_ovf        = w_signed_div & (operand_a == 32'h8000_0000) & (operand_b == 32'hFFFF_FFFF);

   // MULH and MULHSU sign-extend rs1; only MULH sign-extends rs2
   assign w_mul_a_sx   = (funct3[1] ^ funct3[0]) & operand_a[XLEN-1];
   assign w_mul_b_sx   = (funct3[1:0] == 2'b01) & operand_b[XLEN-1];
   assign w_prod       = {{31{r_a[XLEN]}}, r_a} * {{31{r_b[XLEN]}}, r_b};

   div_step u_div_step (
      .i_rem (r_rem),
      .i_div (r_b[XLEN-1:0]),
      .i_bit (r_quo[XLEN-1]),
      .o_rem (w_step_rem),
      .o_q   (w_step_q)
   );

   assign w_fix_quo = (r_neg_q && r_op == F3_DIV) ? -r_quo : r_quo;
   assign w_fix_rem = (r_neg_r && r_op == F3_REM) ? -r_rem : r_rem;

   assign busy   = reset & (((r_state == S_IDLE) & start & ~kill) |
                            (r_state == S_MUL) | (r_state == S_DIV) | (r_state == S_FIX));
   assign done   = r_done;
   assign result = r_result;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_quo    <= '0;
         r_rem    <= '0;
         r_result <= '0;
         r_cnt    <= '0;
         r_op     <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (kill) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: if (start) begin
                  r_op <= funct3;
                  if (!funct3[2]) begin
                     r_a     <= {w_mul_a_sx, operand_a};
                     r_b     <= {w_mul_b_sx, operand_b};
                     r_state <= S_MUL;
                  end else if (w_div_zero) begin
                     r_result <= funct3[1] ? operand_a : '1;
                     r_done   <= 1'b1;
                     r_state  <= S_DONE;
                  end else if (w_ovf) begin
                     r_result <= funct3[1] ? '0 : 32'h8000_0000;
                     r_done   <= 1'b1;
                     r_state  <= S_DONE;
                  end else begin
                     r_quo   <= w_abs_a;
                     r_rem   <= '0;
                     r_b     <= {1'b0, w_abs_b};
                     r_cnt   <= 5'd31;
                     r_neg_q <= w_a_neg ^ w_b_neg;
                     r_neg_r <= w_a_neg;
                     r_state <= S_DIV;
                  end
               end
               S_MUL: begin
                  r_result <= (r_op[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end
               S_DIV: begin
                  // dividend bits shift out of r_quo's top as quotient bits enter the bottom
                  r_rem <= w_step_rem;
                  r_quo <= {r_quo[XLEN-2:0], w_step_q};
                  if (r_cnt == 5'd0) r_state <= S_FIX;
                  else               r_cnt   <= r_cnt - 5'd1;
               end
               S_FIX: begin
                  r_result <= r_op[1] ? w_fix_rem : w_fix_quo;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end
               S_DONE:  r_state <= S_IDLE;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage. It consumes operands and the M-extension selector from the ID/EX pipeline register and returns a 32-bit result. It drives `busy` into the pipeline `busywait` network so ID/EX and upstream stages hold while an operation is in flight. Multiplies take 2 cycles; divides/remainders use a 32-iteration restoring divider.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  valid M-extension op present in EX; held high by the pipeline until `done`.
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `operand_a`  in  32  rs1 value (ID/EX data1).
- `operand_b`  in  32  rs2 value (ID/EX data2).
- `kill`  in  1  synchronous abort (branch flush).
- `busy`  out  1  stall request to the pipeline `busywait` network.
- `done`  out  1  result valid this cycle.
- `result`  out  32  registered result.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE & start & funct3[2]=0 -> MUL; operands latched.
- IDLE & start & funct3[2]=1 -> DIV; latch |a|, |b| for signed ops, plus the quotient and remainder signs; counter = 31.
- Divide by zero (b=0) -> DONE directly. Quotient = 0xFFFFFFFF; remainder = a.
- Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF) -> DONE directly. Quotient = 0x80000000; remainder = 0.
- MUL -> DONE: 66-bit product of 33-bit extended operands. MULHSU: a sign-extended, b zero-extended. MULH: both sign-extended. MULHU: both zero-extended. MUL takes bits [31:0]; the others take [63:32].
- DIV: one restoring step per cycle (shift remainder, subtract, set quotient bit). When the counter reaches 0 -> FIX.
- FIX: negate quotient if signs differ (DIV). Negate remainder if the dividend is negative (REM). Unsigned ops pass through unchanged. -> DONE.
- DONE: `done`=1. The state always returns to IDLE on the next edge, and `start` is ignored in DONE. Back-to-back ops start from IDLE one cycle later.
- `busy` = (IDLE & start & !kill) | MUL | DIV | FIX. It is 0 in DONE, so the pipeline advances on the DONE edge.
- `kill`=1 in any state -> IDLE at the next edge. `done` is not asserted and `result` is unchanged.
- `result` holds its last value outside DONE.
- Reset (async, low) clears all state to IDLE. `result`=0, `done`=0, and `busy` is forced to 0 while reset is low. Reset mid-operation discards the operation.

## Timing
- Cycle 0 is the cycle `start` is first high in IDLE. `busy` is high combinationally in cycle 0.
- MUL family: DONE in cycle 2.
- DIV family: DIV in cycles 1–32, FIX in cycle 33, DONE in cycle 34.
- Div-by-zero and overflow: DONE in cycle 1.
- `result` and `done` are registered and change only on `clk` edges or on reset assertion.

## Structure
- Package `muldiv_pkg`:
  - funct3 localparams (`F3_MUL` … `F3_REMU`).
  - State enum.
  - `XLEN` constant.
- Sub-module `div_step`: combinational restoring step. Inputs: remainder, divisor, next dividend bit. Outputs: new remainder and quotient bit. Instantiated once inside the unit.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) -> `result`=0xFFFFFFEB, `done` in cycle 2, `busy` high in cycles 0–1.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULH on the same operands -> 0x00000000; MULHSU on the same operands -> 0xFFFFFFFF.
- DIV −7 / 2 -> 0xFFFFFFFD and REM −7 / 2 -> 0xFFFFFFFF, each with `done` in cycle 34; DIVU 100 / 7 -> 14.
- DIVU 5 / 0 -> 0xFFFFFFFF and REM 0x80000000 / −1 -> 0, each with `done` in cycle 1.
- Reset low during cycle 10 of a DIV -> `busy`=0 and `result`=0 immediately. After release, a new MUL 3 × 4 completes in cycle 2 with result 12.
- `kill` in cycle 5 of a DIV -> IDLE next edge, no `done`, `result` keeps its prior value. Then two back-to-back MULs -> `done` pulses separated by 3 cycles.
